mult_scheduler: RTL
===================

MULT_SCHEDULER -- requirements
Module: mult_scheduler

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters sharing one matrix multiplier (2..8).
REQ-002 The block SHALL have parameter IDXW, default 2, meaning the grant index width, equal to clog2(NREQ).
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum BUSY cycles before abort (used only with MULT_SCHED_TIMEOUT_EN).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  NREQ  per-requester level request; bit i held high by requester i until done[i].
REQ-007 gnt  output  NREQ  one-hot grant; selects requester i's operands onto the multiplier.
REQ-008 gnt_idx  output  IDXW  binary index of the granted requester, for the operand mux.
REQ-009 mult_on  output  1  level enable to the multiplier; high while the granted operation runs.
REQ-010 mult_done  input  1  single-cycle multiplier completion pulse; result valid in the same cycle.
REQ-011 res_we  output  1  pulse that writes the multiplier result into the granted requester's result register.
REQ-012 done  output  NREQ  single-cycle completion pulse to the granted requester.
REQ-013 err  output  NREQ  single-cycle abort pulse to the granted requester; tied 0 when MULT_SCHED_TIMEOUT_EN is undefined.
REQ-014 busy  output  1  high in every state other than IDLE.

Function
REQ-015 The FSM SHALL have four states: IDLE, SETUP, RUN and FINISH.
REQ-016 IDLE: if req is nonzero, the next state SHALL be SETUP, with gnt/gnt_idx registered from the round-robin choice; otherwise the FSM SHALL stay in IDLE.
REQ-017 Round-robin order: the search SHALL start at (last+1) mod NREQ and pick the first set req bit; last resets to NREQ-1, so requester 0 has first priority after reset.
REQ-018 SETUP SHALL last exactly one cycle, with mult_on low so the operand mux settles; the next state SHALL be RUN.
REQ-019 RUN SHALL hold mult_on=1; mult_done=1 SHALL assert res_we combinationally in that cycle and move the FSM to FINISH.
REQ-020 FINISH SHALL last one cycle: done[gnt_idx]=1 (or err[gnt_idx]=1 on abort), last set to gnt_idx, mult_on low; the next state SHALL be IDLE.
REQ-021 gnt and gnt_idx SHALL be stable from SETUP through FINISH and SHALL be all-zero in IDLE.
REQ-022 Latency from req rise (FSM in IDLE) to done SHALL be 3 cycles plus the multiplier run time N, where N is the number of RUN cycles including the mult_done cycle.
REQ-023 A req bit deasserted after grant SHALL NOT abort the operation; done SHALL still pulse.
REQ-024 mult_done seen in IDLE, SETUP or FINISH SHALL be ignored, with no res_we.
REQ-025 Requests arriving during an operation SHALL be held off and considered only in IDLE; back-to-back operations SHALL have one IDLE cycle between them.
REQ-026 At most one bit of gnt, done or err SHALL be high at any time; done and err SHALL never be high together.

Reset
REQ-027 While rst_n=0, the state SHALL be IDLE; gnt, gnt_idx, mult_on, res_we, done, err and busy SHALL be 0; last SHALL be NREQ-1; the timeout counter SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL drop mult_on immediately (asynchronously), with no done or err pulse; the operation is lost.
REQ-029 Operation SHALL resume on the first rising clk edge after rst_n deasserts.

Configuration
REQ-030 With MULT_SCHED_TIMEOUT_EN defined, a counter SHALL clear on RUN entry and increment each RUN cycle; reaching TIMEOUT without mult_done SHALL force FINISH with err[gnt_idx] pulsed and no done or res_we.
REQ-031 With MULT_SCHED_TIMEOUT_EN defined, mult_done in the same cycle the counter hits TIMEOUT SHALL take priority: normal completion, err=0.
REQ-032 Without MULT_SCHED_TIMEOUT_EN, the block SHALL have no counter, RUN SHALL wait indefinitely, and err SHALL be constant 0.

Verification
REQ-033 Single request, req=4'b0010, mult_done 5 cycles into RUN -> gnt=4'b0010, gnt_idx=1, mult_on high 5 cycles, res_we with mult_done, done=4'b0010 at cycle 8 after req.
REQ-034 Contention, req=4'b1111 held, each requester dropped after its done -> grant order 0,1,2,3, each done exactly once, one IDLE cycle between operations.
REQ-035 Fairness after last=2, req=4'b0101 -> requester 0 granted (wrap), then 2.
REQ-036 Reset mid-RUN with gnt_idx=3 -> all outputs 0 immediately; afterwards req=4'b1000 is re-granted from a fresh start with requester-0 priority.
REQ-037 Timeout with macro on, TIMEOUT=10 and mult_done never asserted -> err=4'b0001 after 10 RUN cycles, done stays 0, FSM returns to IDLE.
REQ-038 Timeout with macro on, mult_done on the counter's terminal cycle -> done pulses and err stays 0; with the macro off, the same stall keeps busy=1 indefinitely.

Source files
------------

// File: rtl/mult_scheduler.sv
// Round-robin scheduler granting one shared matrix multiplier to NREQ requesters.
// Optional RUN-phase abort timer is enabled by defining MULT_SCHED_TIMEOUT_EN.
module mult_scheduler #(
    parameter int NREQ    = 4,
    parameter int IDXW    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            mult_on,
    input  logic            mult_done,
    output logic            res_we,
    output logic [NREQ-1:0] done,
    output logic [NREQ-1:0] err,
    output logic            busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    if (NREQ < 2 || NREQ > 8 || IDXW != $clog2(NREQ) || TIMEOUT < 1) begin : g_bad_param
        $error("mult_scheduler: illegal parameter combination");
    end

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [NREQ-1:0] r_gnt;
    logic [IDXW-1:0] r_gnt_idx;
    logic [IDXW-1:0] r_last;
    logic [IDXW-1:0] w_pick_idx;
    logic [IDXW-1:0] w_cand;
    logic [NREQ-1:0] w_pick_oh;
    logic            w_pick_vld;
    logic            w_timeout;
    logic            w_abort;

    // Search starts one past the last served requester and wraps modulo NREQ.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        w_cand     = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_cand = IDXW'((int'(r_last) + k) % NREQ);
            if (!w_pick_vld && req[w_cand]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_pick_oh             = '0;
        w_pick_oh[w_pick_idx] = 1'b1;
    end

`ifdef MULT_SCHED_TIMEOUT_EN
    localparam int CNTW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CNTW-1:0] r_cnt;
    logic            r_abort;
    logic            w_cnt_hit;

    // r_cnt holds the number of completed RUN cycles; the hit flags the TIMEOUT-th cycle.
    assign w_cnt_hit = (r_cnt == CNTW'(TIMEOUT - 1));
    assign w_timeout = (r_state == S_RUN) && !mult_done && w_cnt_hit;
    assign w_abort   = r_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_abort <= 1'b0;
        end else begin
            case (r_state)
                S_SETUP: begin
                    r_cnt   <= '0;
                    r_abort <= 1'b0;
                end
                S_RUN: begin
                    if (!w_cnt_hit) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    r_abort <= w_timeout;
                end
                default: ;
            endcase
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_abort   = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_pick_vld) w_next_state = S_SETUP;
            S_SETUP:  w_next_state = S_RUN;
            S_RUN:    if (mult_done || w_timeout) w_next_state = S_FINISH;
            S_FINISH: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_last    <= IDXW'(NREQ - 1);
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_vld) begin
                        r_gnt     <= w_pick_oh;
                        r_gnt_idx <= w_pick_idx;
                    end
                end
                S_FINISH: begin
                    r_last    <= r_gnt_idx;
                    r_gnt     <= '0;
                    r_gnt_idx <= '0;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from state so an asynchronous reset clears them at once.
    assign gnt     = r_gnt;
    assign gnt_idx = r_gnt_idx;
    assign mult_on = (r_state == S_RUN);
    assign res_we  = (r_state == S_RUN) && mult_done;
    assign busy    = (r_state != S_IDLE);
    assign done    = ((r_state == S_FINISH) && !w_abort) ? r_gnt : '0;
`ifdef MULT_SCHED_TIMEOUT_EN
    assign err     = ((r_state == S_FINISH) && w_abort) ? r_gnt : '0;
`else
    assign err     = '0;
`endif

`ifndef SYNTHESIS
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_done_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(done));
    a_done_err_excl: assert property (@(posedge clk) disable iff (!rst_n) (done & err) == '0);
`endif

endmodule
